// File: rtl/aether_engine_stream_mem.sv
// Strided single-port memory engine: streams an inclusive range [start..end] with a fixed stride.
// Latency: a write commits in the cycle it is accepted; a read beat is offered 2 cycles after issue
//   (1-cycle BRAM read, then a 2-entry output FIFO).
// Backpressure: writes stall while wr_valid_i is low. Read issue stops while FIFO + in-flight would overflow.
//   rd_data_o/rd_valid_o hold steady while rd_ready_i is low.
// Optional feature: define AETHER_MEM_FILL_EN to enable cmd 3 (FILL).
// Ports:
//   clk_i, rst_i (sync, active-high)
//   command: cmd_i, cmd_valid_i, cmd_ready_o, start_addr_i, end_addr_i, stride_i, fill_data_i
//   write:   wr_data_i, wr_valid_i, wr_ready_o
//   read:    rd_data_o, rd_valid_o, rd_ready_i
//   status:  busy_o, task_done_o, cmd_error_o

// Generic first-word-fall-through FIFO. head_dat is valid whenever count != 0.
// Latency: a pushed word is visible at head one cycle later.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module aether_engine_stream_mem_fifo #(
  parameter int Width = 16,
  parameter int Depth = 2,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [Width-1:0] push_dat,
  input  logic             pop,
  output logic [Width-1:0] head_dat,
  output logic [CntW-1:0]  count
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] store [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;

  always_ff @(posedge clk_i) begin
    if (push) store[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_dat = store[rd_ptr];
endmodule

module aether_engine_stream_mem #(
  parameter int DataWidth   = 16,
  parameter int AddrWidth   = 16,
  parameter int StrideWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             cmd_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [AddrWidth-1:0]   start_addr_i,
  input  logic [AddrWidth-1:0]   end_addr_i,
  input  logic [StrideWidth-1:0] stride_i,
  input  logic [DataWidth-1:0]   fill_data_i,
  input  logic [DataWidth-1:0]   wr_data_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  output logic [DataWidth-1:0]   rd_data_o,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic                   busy_o,
  output logic                   task_done_o,
  output logic                   cmd_error_o
);
  localparam int Depth = 2 ** AddrWidth;
  localparam logic [1:0] CmdIdle  = 2'd0;
  localparam logic [1:0] CmdWrite = 2'd1;
  localparam logic [1:0] CmdRead  = 2'd2;
  localparam logic [1:0] CmdFill  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
`ifdef AETHER_MEM_FILL_EN
    , S_FILL
`endif
  } state_t;

  state_t                 state;
  logic [AddrWidth-1:0]   addr;
  logic [AddrWidth-1:0]   end_q;
  logic [StrideWidth-1:0] stride_q;
  logic [AddrWidth:0]     next_addr;
  logic                   last_beat;
  logic                   cmd_take;
  logic                   bad_cmd;
  logic                   wr_fire;
  logic                   mem_we;
  logic [DataWidth-1:0]   mem_wdat;
  logic                   rd_issue;
  logic                   rd_pop;
  logic                   pipe_vld;
  logic [DataWidth-1:0]   pipe_dat;
  logic [DataWidth-1:0]   head_dat;
  logic [1:0]             fifo_cnt;
  logic [1:0]             fifo_left;
  logic [DataWidth-1:0]   mem [Depth];

  // One extra bit so a step past the top of memory ends the task instead of wrapping.
  assign next_addr = {1'b0, addr} + (AddrWidth + 1)'(stride_q);
  assign last_beat = next_addr > {1'b0, end_q};
  assign cmd_take  = cmd_valid_i && cmd_ready_o && (cmd_i != CmdIdle);
  assign wr_fire   = wr_ready_o && wr_valid_i;

`ifdef AETHER_MEM_FILL_EN
  logic [DataWidth-1:0] fill_q;
  assign bad_cmd  = end_addr_i < start_addr_i;
  assign mem_we   = (wr_fire || (state == S_FILL)) && !rst_i;
  assign mem_wdat = (state == S_FILL) ? fill_q : wr_data_i;
`else
  logic unused_fill;
  assign unused_fill = ^fill_data_i;
  assign bad_cmd  = (end_addr_i < start_addr_i) || (cmd_i == CmdFill);
  assign mem_we   = wr_fire && !rst_i;
  assign mem_wdat = wr_data_i;
`endif

  // Occupancy counted after this cycle's pop, so a draining consumer keeps 1 beat/cycle.
  assign rd_pop    = rd_valid_o && rd_ready_i;
  assign fifo_left = fifo_cnt - {1'b0, rd_pop};
  assign rd_issue  = (state == S_READ) && ((fifo_left + {1'b0, pipe_vld}) < 2'd2);

  always_ff @(posedge clk_i) begin
    if (mem_we)   mem[addr] <= mem_wdat;
    if (rd_issue) pipe_dat  <= mem[addr];
  end

  aether_engine_stream_mem_fifo #(.Width(DataWidth), .Depth(2)) u_rd_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (pipe_vld),
    .push_dat (pipe_dat),
    .pop      (rd_pop),
    .head_dat (head_dat),
    .count    (fifo_cnt)
  );

  assign rd_valid_o = fifo_cnt != 2'd0;
  assign rd_data_o  = rd_valid_o ? head_dat : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cmd_ready_o <= 1'b1;
      wr_ready_o  <= 1'b0;
      busy_o      <= 1'b0;
      task_done_o <= 1'b0;
      cmd_error_o <= 1'b0;
      pipe_vld    <= 1'b0;
      addr        <= '0;
      end_q       <= '0;
      stride_q    <= '0;
`ifdef AETHER_MEM_FILL_EN
      fill_q      <= '0;
`endif
    end else begin
      task_done_o <= 1'b0;
      cmd_error_o <= 1'b0;
      pipe_vld    <= rd_issue;
      case (state)
        S_IDLE: begin
          if (cmd_take) begin
            if (bad_cmd) begin
              cmd_error_o <= 1'b1;
            end else begin
              addr        <= start_addr_i;
              end_q       <= end_addr_i;
              stride_q    <= (stride_i == '0) ? StrideWidth'(1) : stride_i;
              cmd_ready_o <= 1'b0;
              busy_o      <= 1'b1;
              if (cmd_i == CmdWrite) begin
                state      <= S_WRITE;
                wr_ready_o <= 1'b1;
              end else if (cmd_i == CmdRead) begin
                state <= S_READ;
              end
`ifdef AETHER_MEM_FILL_EN
              else if (cmd_i == CmdFill) begin
                state  <= S_FILL;
                fill_q <= fill_data_i;
              end
`endif
            end
          end
        end
        S_WRITE: begin
          if (wr_fire) begin
            addr <= next_addr[AddrWidth-1:0];
            if (last_beat) begin
              state       <= S_DONE;
              wr_ready_o  <= 1'b0;
              task_done_o <= 1'b1;
            end
          end
        end
`ifdef AETHER_MEM_FILL_EN
        S_FILL: begin
          addr <= next_addr[AddrWidth-1:0];
          if (last_beat) begin
            state       <= S_DONE;
            task_done_o <= 1'b1;
          end
        end
`endif
        S_READ: begin
          if (rd_issue) begin
            addr <= next_addr[AddrWidth-1:0];
            if (last_beat) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((fifo_left == 2'd0) && !pipe_vld) begin
            state       <= S_DONE;
            task_done_o <= 1'b1;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          cmd_ready_o <= 1'b1;
          wr_ready_o  <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aether_engine_stream_mem.sv
// Self-checking bench for aether_engine_stream_mem: directed scenarios plus randomized
// write/read traffic against an address-keyed reference memory.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_aether_engine_stream_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] start_addr;
  logic [15:0] end_addr;
  logic [7:0]  stride;
  logic [15:0] fill_data;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic        task_done;
  logic        cmd_error;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] ref_mem [int];
  int aq[$];

  always #5 clk = ~clk;

  aether_engine_stream_mem #(.DataWidth(16), .AddrWidth(16), .StrideWidth(8)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_i(cmd), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .start_addr_i(start_addr), .end_addr_i(end_addr), .stride_i(stride), .fill_data_i(fill_data),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .busy_o(busy), .task_done_o(task_done), .cmd_error_o(cmd_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Address sequence straight from the range rules: start, start+s, ... while <= end.
  task automatic make_addrs(input int s, input int e, input int st);
    int stp;
    stp = (st == 0) ? 1 : st;
    aq.delete();
    for (int a = s; a <= e; a += stp) aq.push_back(a);
  endtask

  task automatic send_cmd(input logic [1:0] c, input int s, input int e, input int st, input int fv);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd        = c;
    start_addr = 16'(s);
    end_addr   = 16'(e);
    stride     = 8'(st);
    fill_data  = 16'(fv);
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd        = 2'd0;
  endtask

  // pat < 0: random data, else pat+index. Optional fixed gap before beat gap_at, plus random gaps.
  task automatic do_write(input int s, input int e, input int st, input int pat,
                          input int gap_at, input int gap_len, input int gap_pct);
    int idx = 0;
    int n = 0;
    int gap_left;
    logic gap;
    make_addrs(s, e, st);
    send_cmd(2'd1, s, e, st, 0);
    gap_left = gap_len;
    while (idx < aq.size() && n < 4000) begin
      gap = 1'b0;
      if (idx == gap_at && gap_left > 0) begin
        gap = 1'b1;
        gap_left--;
      end else if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        gap = 1'b1;
      end
      if (gap) begin
        wr_valid = 1'b0;
      end else begin
        wr_valid = 1'b1;
        wr_data  = (pat < 0) ? 16'($urandom) : 16'(pat + idx);
      end
      if (wr_valid && wr_ready) begin
        ref_mem[aq[idx]] = wr_data;
        idx++;
      end
      @(negedge clk);
      n++;
    end
    wr_valid = 1'b0;
    check("wr_beats", idx, aq.size());
    check("wr_done_pulse", task_done, 1);
    check("wr_ready_after", wr_ready, 0);
    @(negedge clk);
    check("wr_done_once", task_done, 0);
    check("wr_busy_after", busy, 0);
  endtask

  // mode 0: always ready, 1: toggle ready each cycle, 2: random ready.
  // abort_after > 0: return right after that many beats, task still running.
  task automatic do_read(input int s, input int e, input int st, input int mode, input int abort_after);
    int idx = 0;
    int n = 0;
    int gaps = 0;
    logic hold = 1'b0;
    logic [15:0] hold_dat = '0;
    logic [15:0] exp_q[$];
    make_addrs(s, e, st);
    foreach (aq[i]) exp_q.push_back(ref_mem[aq[i]]);
    send_cmd(2'd2, s, e, st, 0);
    while (idx < exp_q.size() && n < 4000) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (n % 2) == 0;
        default: rd_ready = 1'($urandom_range(1));
      endcase
      if (hold) begin
        check("rd_stall_vld", rd_valid, 1);
        check("rd_stall_dat", rd_data, hold_dat);
      end
      hold = 1'b0;
      if (rd_valid && rd_ready) begin
        check("rd_beat", rd_data, exp_q[idx]);
        idx++;
      end else if (rd_valid) begin
        hold     = 1'b1;
        hold_dat = rd_data;
      end else begin
        check("rd_data_zero", rd_data, 0);
        if (idx > 0) gaps++;
      end
      @(negedge clk);
      n++;
      if (abort_after > 0 && idx >= abort_after) return;
    end
    rd_ready = 1'b0;
    check("rd_beats", idx, exp_q.size());
    if (mode == 0) check("rd_no_gaps", gaps, 0);
    check("rd_done_pulse", task_done, 1);
    @(negedge clk);
    check("rd_done_once", task_done, 0);
    check("rd_busy_after", busy, 0);
    check("rd_valid_after", rd_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; cmd = 2'd0; cmd_valid = 1'b0; start_addr = '0; end_addr = '0; stride = '0;
    fill_data = '0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_task_done", task_done, 0);
    check("rst_cmd_error", cmd_error, 0);
    check("rst_wr_ready", wr_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    // IDLE command is a no-op
    send_cmd(2'd0, 0, 3, 1, 0);
    check("idle_no_err", cmd_error, 0);
    check("idle_no_busy", busy, 0);
    check("idle_ready", cmd_ready, 1);

    // A0..A3 with a 2-cycle valid gap, then read back at full rate
    do_write('h10, 'h13, 1, 'hA0, 2, 2, 0);
    do_read('h10, 'h13, 1, 0, 0);

    // Strided read 0..9 step 4 -> addresses 0,4,8
    do_write(0, 9, 1, -1, -1, 0, 0);
    do_read(0, 9, 4, 0, 0);

    // Backpressure: toggling ready
    do_write('h40, 'h47, 1, -1, -1, 0, 30);
    do_read('h40, 'h47, 1, 1, 0);

    // Bad range: error pulse, no done, memory untouched
    send_cmd(2'd1, 5, 4, 1, 0);
    check("err_pulse", cmd_error, 1);
    check("err_ready", cmd_ready, 1);
    check("err_busy", busy, 0);
    @(negedge clk);
    check("err_once", cmd_error, 0);
    check("err_no_done", task_done, 0);
    do_read(0, 9, 1, 0, 0);

`ifdef AETHER_MEM_FILL_EN
    send_cmd(2'd3, 'h20, 'h2F, 1, 'hBEEF);
    n = 0;
    while (!task_done && n < 100) begin
      check("fill_wr_ready", wr_ready, 0);
      @(negedge clk);
      n++;
    end
    check("fill_done", task_done, 1);
    for (int a = 'h20; a <= 'h2F; a++) ref_mem[a] = 16'hBEEF;
    @(negedge clk);
    do_read('h20, 'h2F, 1, 0, 0);
`else
    send_cmd(2'd3, 'h20, 'h2F, 1, 'hBEEF);
    check("fill_err_pulse", cmd_error, 1);
    check("fill_err_busy", busy, 0);
    @(negedge clk);
    check("fill_err_no_done", task_done, 0);
`endif

    // Top-of-memory range: stops at 0xFFFE, no wrap
    do_write('hFFF0, 'hFFFF, 7, -1, -1, 0, 10);
    do_read('hFFF0, 'hFFFF, 7, 0, 0);
    do_read('hFFF0, 'hFFFF, 1, 2, 0);
    // Single-beat task and maximum stride
    do_write('h300, 'h300, 3, 'h1234, -1, 0, 0);
    do_read('h300, 'h300, 0, 0, 0);
    do_read(0, 'h47, 255, 0, 0);

    // Reset in the middle of a read, then a stride-0 write
    do_read('h40, 'h47, 1, 0, 3);
    rst = 1'b1;
    rd_ready = 1'b0;
    @(negedge clk);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    do_write('h200, 'h201, 0, 'h55, -1, 0, 0);
    do_read('h200, 'h201, 1, 0, 0);
    do_read('h40, 'h47, 1, 2, 0);

    // Randomized traffic in a pre-written region
    do_write('h1000, 'h10FF, 1, -1, -1, 0, 20);
    for (int it = 0; it < 14; it++) begin
      int s;
      int e;
      int st;
      s  = 'h1000 + int'($urandom_range(200));
      e  = s + int'($urandom_range(40));
      if (e > 'h10FF) e = 'h10FF;
      st = int'($urandom_range(6));
      if ($urandom_range(1) == 1) do_write(s, e, st, -1, -1, 0, int'($urandom_range(50)));
      do_read(s, e, int'($urandom_range(6)), int'($urandom_range(2)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
